ssd_multiplex_ctrl: RTL and testbench

Parametrised multiplexed seven-segment controller that replaces the hand-coded scan/decode logic in the top level.
- Latches a binary value through a load/busy handshake.
- Optionally converts the value to BCD with a sequential double-dabble engine.
- Time-multiplexes NUM_DIGITS digits onto shared active-low anodes/cathodes.
- Supports per-digit decimal points, leading-zero blanking and overflow indication.

---
 rtl/ssd_multiplex_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ssd_multiplex_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_multiplex_ctrl.sv
// ssd_multiplex_ctrl: latches a binary value through a load/busy handshake,
// optionally converts it to BCD with a sequential double-dabble engine, and
// time-multiplexes NUM_DIGITS digits onto shared active-low anodes/cathodes.
// Supports per-digit decimal points, leading-zero blanking and an overflow
// indication (dashes) for decimal values that do not fit.
// Optional build macro SSD_BRIGHTNESS_EN adds a 4-bit brightness input that
// PWM-dims the selected anode inside each digit slot.
module ssd_multiplex_ctrl #(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_BITS = 17,
    parameter int DATA_W        = 4 * NUM_DIGITS
) (
    input  logic                  ClkPort,
    input  logic                  Reset,
    input  logic                  load,
    input  logic [DATA_W-1:0]     value,
    input  logic                  mode,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  blank_lz,
`ifdef SSD_BRIGHTNESS_EN
    input  logic [3:0]            brightness,
`endif
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            cathodes
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t                   state_reg, state_next;
    logic [DATA_W-1:0]        shift_reg;
    logic [BCD_W-1:0]         bcd_reg;
    logic [BCD_W-1:0]         bcd_adj;
    logic                     mode_reg;
    logic                     ovf_reg;
    logic [CNT_W-1:0]         step_cnt_reg;
    logic [BCD_W-1:0]         disp_reg;
    logic                     overflow_reg;

    logic [SCAN_DIV_BITS-1:0] prescaler_reg;
    logic [IDX_W-1:0]         index_reg;
    logic [NUM_DIGITS-1:0]    an_reg, an_next;
    logic [7:0]               cathodes_reg, cathodes_next;

    logic [3:0]               nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]    upper_zero;
    logic                     blank_digit;
    logic                     pwm_on;

    // Segment patterns a..g, 0 = segment lit.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'b0000001;
            4'h1: seg_decode = 7'b1001111;
            4'h2: seg_decode = 7'b0010010;
            4'h3: seg_decode = 7'b0000110;
            4'h4: seg_decode = 7'b1001100;
            4'h5: seg_decode = 7'b0100100;
            4'h6: seg_decode = 7'b0100000;
            4'h7: seg_decode = 7'b0001111;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0000100;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b1100000;
            4'hC: seg_decode = 7'b0110001;
            4'hD: seg_decode = 7'b1000010;
            4'hE: seg_decode = 7'b0110000;
            default: seg_decode = 7'b0111000;
        endcase
    endfunction

    // Per-nibble views: double-dabble add-3 correction, display nibble split
    // and "this digit and everything above it is zero" chain for blanking.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 :
                                        bcd_reg[4*gi +: 4];
            assign nib[gi] = disp_reg[4*gi +: 4];
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign upper_zero[gi] = (nib[gi] == 4'd0);
            end else begin : g_chain
                assign upper_zero[gi] = (nib[gi] == 4'd0) && upper_zero[gi+1];
            end
        end
    endgenerate

    // Load FSM state register.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Load FSM next state: hex goes straight to commit, decimal converts first.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = mode ? CONV : COMMIT;
            CONV:    if (step_cnt_reg == CNT_W'(DATA_W - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    // Capture, double-dabble stepping and commit of the display nibbles.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            shift_reg    <= '0;
            bcd_reg      <= '0;
            mode_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            step_cnt_reg <= '0;
            disp_reg     <= '0;
            overflow_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            if (load) begin
                shift_reg    <= value;
                mode_reg     <= mode;
                bcd_reg      <= '0;
                ovf_reg      <= 1'b0;
                step_cnt_reg <= '0;
            end
        end else if (state_reg == CONV) begin
            // A 1 leaving the top BCD nibble means the value needs more digits.
            {bcd_reg, shift_reg} <= {bcd_adj[BCD_W-2:0], shift_reg, 1'b0};
            ovf_reg              <= ovf_reg | bcd_adj[BCD_W-1];
            step_cnt_reg         <= step_cnt_reg + CNT_W'(1);
        end else begin
            disp_reg     <= mode_reg ? bcd_reg : BCD_W'(shift_reg);
            overflow_reg <= mode_reg & ovf_reg;
        end
    end

`ifdef SSD_BRIGHTNESS_EN
    assign pwm_on = (prescaler_reg[SCAN_DIV_BITS-1 -: 4] < brightness);
`else
    assign pwm_on = 1'b1;
`endif

    // Blanking is suppressed while overflow dashes are shown; digit 0 always lit.
    assign blank_digit = blank_lz && !overflow_reg && (index_reg != '0) &&
                         upper_zero[index_reg];

    // Anode/cathode pattern for the currently selected digit.
    always_comb begin
        an_next       = '1;
        cathodes_next = 8'hFF;
        if (!blank_digit) begin
            if (pwm_on) an_next = ~(NUM_DIGITS'(1) << index_reg);
            cathodes_next = {overflow_reg ? 7'b1111110 : seg_decode(nib[index_reg]),
                             ~dp_mask[index_reg]};
        end
    end

    // Free-running prescaler, digit index and registered display outputs.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            prescaler_reg <= '0;
            index_reg     <= '0;
            an_reg        <= '1;
            cathodes_reg  <= 8'hFF;
        end else begin
            prescaler_reg <= prescaler_reg + SCAN_DIV_BITS'(1);
            if (&prescaler_reg) begin
                if (index_reg == IDX_W'(NUM_DIGITS - 1)) index_reg <= '0;
                else                                     index_reg <= index_reg + IDX_W'(1);
            end
            an_reg       <= an_next;
            cathodes_reg <= cathodes_next;
        end
    end

    assign overflow = overflow_reg;
    assign an       = an_reg;
    assign cathodes = cathodes_reg;

endmodule

// File: tb/tb_ssd_multiplex_ctrl.sv
// Bench for ssd_multiplex_ctrl (8 digits, SCAN_DIV_BITS=4): a digit-level
// model checked every cycle plus directed literal expectations.
module tb_ssd_multiplex_ctrl;

    localparam int ND  = 8;
    localparam int SDB = 4;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] value = '0;
    logic          mode = 1'b0;
    logic [ND-1:0] dp_mask = '0;
    logic          blank_lz = 1'b0;
    logic          busy, overflow;
    logic [ND-1:0] an;
    logic [7:0]    cathodes;
`ifdef SSD_BRIGHTNESS_EN
    logic [3:0]    brightness = 4'd15;
`endif

    int vectors = 0;
    int miscompares = 0;

    ssd_multiplex_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV_BITS(SDB), .DATA_W(DW)) dut (
        .ClkPort(clk), .Reset(rst), .load(load), .value(value), .mode(mode),
        .dp_mask(dp_mask), .blank_lz(blank_lz),
`ifdef SSD_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .busy(busy), .overflow(overflow), .an(an), .cathodes(cathodes));

    always #5 clk = ~clk;

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: digits on display, pending result, busy countdown.
    int           m_cycle = 0;
    int           m_busy = 0;
    int           m_disp [ND];
    int           p_disp [ND];
    bit           m_ovf = 0, p_ovf = 0;
    logic [ND-1:0] exp_an = '1;
    logic [7:0]   exp_cath = 8'hFF;
    bit           cmp_en = 0;

    initial for (int i = 0; i < ND; i++) m_disp[i] = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cycle = 0; m_busy = 0; m_ovf = 0;
            for (int i = 0; i < ND; i++) m_disp[i] = 0;
            exp_an = '1; exp_cath = 8'hFF;
        end else begin
            int  idx;
            bit  blank, on;
            idx   = (m_cycle / (1 << SDB)) % ND;
            blank = blank_lz && !m_ovf && idx > 0;
            for (int j = idx; j < ND; j++) if (m_disp[j] != 0) blank = 0;
            on = 1;
`ifdef SSD_BRIGHTNESS_EN
            on = ((m_cycle % 16) < int'(brightness));
`endif
            exp_an = '1;
            exp_cath = 8'hFF;
            if (!blank) begin
                if (on) exp_an[idx] = 1'b0;
                exp_cath = {m_ovf ? 7'b1111110 : SEG[m_disp[idx]], ~dp_mask[idx]};
            end
            m_cycle++;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_disp = p_disp;
                    m_ovf  = p_ovf;
                end
            end else if (load) begin
                longint v;
                v = longint'(value);
                for (int i = 0; i < ND; i++)
                    p_disp[i] = mode ? int'((v / (10 ** i)) % 10) : int'((v >> (4 * i)) & 15);
                p_ovf  = mode && (v >= 100000000);
                m_busy = mode ? DW + 1 : 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(m_busy > 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("an", 32'(an), 32'(exp_an));
            if (exp_an != '1) chk("cathodes", 32'(cathodes), 32'(exp_cath));
        end
    end

    task automatic do_load(input logic [DW-1:0] v, input logic m);
        load = 1'b1; value = v; mode = m;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic busy_len(input int exp_len);
        int n = 0;
        while (busy && n < 200) begin n++; @(negedge clk); end
        chk("busy_len", 32'(n), 32'(exp_len));
    endtask

    task automatic check_digit(input int idx, input logic [7:0] exp_c);
        int n = 0;
        logic [ND-1:0] want;
        want = ~(ND'(1) << idx);
        while (an !== want && n < 400) begin n++; @(negedge clk); end
        chk($sformatf("digit%0d_seen", idx), 32'(an), 32'(want));
        chk($sformatf("digit%0d_cath", idx), 32'(cathodes), 32'(exp_c));
    endtask

    task automatic low_scan(input logic [ND-1:0] exp_low, input string name);
        logic [ND-1:0] seen = '0;
        for (int i = 0; i < 2 * ND * (1 << SDB) + 4; i++) begin
            seen |= ~an;
            @(negedge clk);
        end
        chk(name, 32'(seen), 32'(exp_low));
    endtask

    initial begin
        @(negedge clk);
        cmp_en = 1;
        // 1. reset state, then all zeros after one scan
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_cath", 32'(cathodes), 32'hFF);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (140) @(negedge clk);
        check_digit(0, 8'b00000011);
        check_digit(5, 8'b00000011);

        // 2. hex load
        do_load(32'h1234ABCD, 1'b0);
        busy_len(1);
        check_digit(0, 8'b10000101);
        check_digit(7, 8'b10011111);
        chk("hex_ovf", 32'(overflow), 32'd0);

        // 3. decimal load
        do_load(32'd12345678, 1'b1);
        busy_len(33);
        check_digit(7, 8'b10011111);
        check_digit(4, 8'b10011001);
        check_digit(0, 8'b00000001);
        chk("dec_ovf", 32'(overflow), 32'd0);

        // 4. decimal overflow, then hex clears it
        do_load(32'd100000000, 1'b1);
        busy_len(33);
        chk("ovf_set", 32'(overflow), 32'd1);
        check_digit(3, 8'b11111101);
        check_digit(7, 8'b11111101);
        do_load(32'h0, 1'b0);
        busy_len(1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // 5. leading-zero blanking and decimal point
        blank_lz = 1'b1;
        do_load(32'h000000A5, 1'b0);
        busy_len(1);
        low_scan(8'h03, "blank_a5");
        do_load(32'h0, 1'b0);
        busy_len(1);
        low_scan(8'h01, "blank_zero");
        check_digit(0, 8'b00000011);
        dp_mask = 8'h01;
        repeat (2) @(negedge clk);
        check_digit(0, 8'b00000010);
        dp_mask = 8'h00;
        blank_lz = 1'b0;

        // 6. load while busy is dropped; reset aborts a conversion
        do_load(32'd99999999, 1'b1);
        repeat (4) @(negedge clk);
        do_load(32'h5, 1'b0);
        busy_len(28);
        check_digit(0, 8'b00001001);
        check_digit(6, 8'b00001001);
        do_load(32'd87654321, 1'b1);
        repeat (9) @(negedge clk);
        chk("busy_before_rst", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_digit(0, 8'b00000011);
        check_digit(7, 8'b00000011);
        chk("rst_abort_ovf", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
